// File: rtl/lsl8_seq.sv
// Iterative logical-shift-left unit. It shifts up to STEP_MAX bits per clock through one mx4 stage
// and flags any 1 shifted out of the MSB end. It has valid/ready handshakes on input and output.
module lsl8_seq #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SHAMT_W  = 3,
  parameter int unsigned STEP_MAX = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   d_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   d_out,
  output logic               ovf,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_acc, w_acc_nxt;
  logic [SHAMT_W-1:0] r_rem, w_rem_nxt;
  logic               r_ovf, w_ovf_nxt;

  logic [1:0]         w_step;
  logic [WIDTH-1:0]   w_shl;
  logic               w_lost;
  logic [SHAMT_W-1:0] w_rem_left;

  // Step is min(rem, STEP_MAX); rem is never 0 while in StShift.
  always_comb begin
    w_step     = (r_rem > SHAMT_W'(STEP_MAX)) ? 2'(STEP_MAX) : r_rem[1:0];
    w_rem_left = r_rem - SHAMT_W'(w_step);
  end

  // Per-bit 4-way mux, same structure as the right shifters.
  always_comb begin
    w_shl  = r_acc;
    w_lost = 1'b0;
    case (w_step)
      2'd0: begin
        w_shl  = r_acc;
        w_lost = 1'b0;
      end
      2'd1: begin
        w_shl  = {r_acc[WIDTH-2:0], 1'b0};
        w_lost = r_acc[WIDTH-1];
      end
      2'd2: begin
        w_shl  = {r_acc[WIDTH-3:0], 2'b00};
        w_lost = |r_acc[WIDTH-1 -: 2];
      end
      default: begin
        w_shl  = {r_acc[WIDTH-4:0], 3'b000};
        w_lost = |r_acc[WIDTH-1 -: 3];
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_rem_nxt   = r_rem;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_acc_nxt   = d_in;
          w_rem_nxt   = shamt;
          w_ovf_nxt   = 1'b0;
          w_state_nxt = (shamt == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        w_acc_nxt = w_shl;
        w_ovf_nxt = r_ovf | w_lost;
        w_rem_nxt = w_rem_left;
        if (w_rem_left == '0) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_acc   <= '0;
      r_rem   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_rem   <= w_rem_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state == StShift) || (r_state == StDone);
  assign d_out     = r_acc;
  assign ovf       = r_ovf;

endmodule

// File: doc/lsl8_seq.md
Name: lsl8_seq

Overview:
Iterative 8-bit logical-shift-left unit. It is the left-direction companion of the team's combinational right shifters. An operand and a shift amount are accepted through a valid/ready handshake. The unit shifts left by up to STEP_MAX positions per clock, using the same 4-way mux per bit as the existing shifters. The result and an overflow flag (any 1 shifted out) are presented through a valid/ready handshake. It sits between the operand register file and the ALU result mux, for shift amounts too large for the single-cycle path.

Parameters:
WIDTH, 8, operand/result width in bits
SHAMT_W, 3, shift-amount width (max shift 2^SHAMT_W-1 = 7, always < WIDTH)
STEP_MAX, 3, maximum positions shifted per clock (one mx4 stage)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  operand/shamt offered
in_ready  output  1  unit can accept operand (IDLE only)
d_in  input  WIDTH  operand, sampled on in handshake only
shamt  input  SHAMT_W  left-shift amount, sampled on in handshake only
out_valid  output  1  result available (DONE only)
out_ready  input  1  consumer accepts result
d_out  output  WIDTH  shifted result, zeros filled in from LSB
ovf  output  1  1 if any shifted-out bit was 1
busy  output  1  high in SHIFT and DONE

Behaviour:
- Single clock domain. reset_n is synchronous and active-low; it is only acted on at a clk rising edge.
- Reset (reset_n=0 at an edge) forces state=IDLE, acc=0, rem=0, ovf=0. Outputs after that edge: in_ready=1, out_valid=0, d_out=0, ovf=0, busy=0.
- Reset mid-operation aborts the shift immediately, discards the operand, and produces no out_valid.
- All outputs are decoded from registered state. There is no combinational path from any input to any output.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1: acc<=d_in, rem<=shamt, ovf<=0.
  - Next state is DONE if shamt==0, else SHIFT.
- SHIFT:
  - step = min(rem, STEP_MAX).
  - acc <= acc << step, zero-filled.
  - ovf <= ovf | (OR of acc[WIDTH-1 -: step]).
  - rem <= rem - step.
  - Go to DONE when rem - step == 0, else stay in SHIFT.
  - in_valid is ignored.
- DONE:
  - out_valid=1; d_out=acc; ovf holds its value.
  - d_out and ovf stay stable while out_ready=0.
  - On out_ready=1: go to IDLE. in_ready rises the cycle after the out handshake; there is no same-cycle accept.
  - in_valid is ignored.
- Latency: if the in handshake is at edge T, out_valid is first high after edge T+1+ceil(shamt/STEP_MAX).
  - shamt=0 -> T+1
  - shamt 1..3 -> T+2
  - shamt 4..6 -> T+3
  - shamt 7 -> T+4
- Maximum throughput is one operation per 2+ceil(shamt/STEP_MAX) cycles.
- out_ready is don't-care outside DONE.
- d_out shows acc in all states. It is meaningful only while out_valid=1.
- Width rule: the shift never exceeds WIDTH-1, so no shift amount of WIDTH or more is possible. The intermediate acc is exactly WIDTH bits with no extension.

Test Plan:
1. After reset: in_ready=1, out_valid=0, d_out=8'h00, ovf=0, busy=0. Then d_in=8'hB5, shamt=3, single in handshake at T -> out_valid at T+2, d_out=8'hA8, ovf=1.
2. d_in=8'h81, shamt=0 -> out_valid at T+1, d_out=8'h81, ovf=0.
3. d_in=8'h01, shamt=7 -> out_valid at T+4, d_out=8'h80, ovf=0. Then d_in=8'h03, shamt=7 -> d_out=8'h80, ovf=1 (steps 3,3,1).
4. Backpressure: d_in=8'h0F, shamt=4, out_ready=0 for 5 cycles in DONE, in_valid pulsed with d_in=8'hFF:
   - out_valid stays 1, d_out=8'hF0, ovf=0 throughout.
   - in_ready=0; the 8'hFF pulse is ignored.
   - When out_ready=1: IDLE next cycle.
5. Reset mid-op: shamt=7 accepted, reset_n=0 one cycle during SHIFT:
   - Next cycle all outputs at reset values; no out_valid ever appears for the aborted op.
   - After release, d_in=8'h11, shamt=2 -> d_out=8'h44, ovf=0 at T+2.
6. Back-to-back with in_valid and out_ready held high, ops (8'h80,1) then (8'h40,1):
   - First op: d_out=8'h00, ovf=1.
   - Second op: in_ready=1 exactly one cycle after the first out handshake; d_out=8'h80, ovf=0.
